// File: rtl/key_pkg.sv
// Shared types and helpers for the multi-channel key debouncer with auto-repeat.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HOLD   = 2'd3
  } rep_state_e;

  function automatic int ms_to_cyc(input int freq, input int ms);
    return freq / 1000 * ms;
  endfunction

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce filter, auto-repeat FSM and pulse registers.
// Works in "pressed = 1" polarity; the top maps pin polarity in and out.
//
// state  | meaning
// IDLE   | key released, nothing scheduled
// DELAY  | press accepted, timing the initial repeat delay
// REPEAT | periodic repeat pulses at the repeat rate
// HOLD   | key held with repeat disabled; waits for release only
module key_channel
  import key_pkg::*;
#(
  parameter int DB_CYC = 1,
  parameter int RD_CYC = 1,
  parameter int RR_CYC = 1,
  parameter int CNT_W  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_raw,
  input  logic repeat_en,
  output logic stable,
  output logic key_press,
  output logic key_release,
  output logic key_event
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYC - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt, rcnt_n;
  rep_state_e       state, state_n;
  logic             accept, acc_press, acc_rel, rep_pulse;

  assign accept    = (s2 != stable) && (dcnt == DB_LAST);
  assign acc_press = accept & s2;
  assign acc_rel   = accept & ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      stable      <= 1'b0;
      dcnt        <= '0;
      rcnt        <= '0;
      state       <= IDLE;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_event   <= 1'b0;
    end else begin
      s1 <= pressed_raw;
      s2 <= s1;
      // Any return to the accepted level restarts the stability window.
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
      rcnt        <= rcnt_n;
      state       <= state_n;
      key_press   <= acc_press;
      key_release <= acc_rel;
      key_event   <= acc_press | rep_pulse;
    end
  end

  always_comb begin
    state_n   = state;
    rcnt_n    = rcnt;
    rep_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (acc_press) begin
          state_n = repeat_en ? DELAY : HOLD;
          rcnt_n  = '0;
        end
      end
      DELAY: begin
        if (!repeat_en) begin
          state_n = HOLD;
          rcnt_n  = '0;
        end else if (rcnt == RD_LAST) begin
          rep_pulse = 1'b1;
          rcnt_n    = '0;
          state_n   = REPEAT;
        end else begin
          rcnt_n = rcnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (!repeat_en) begin
          state_n = HOLD;
          rcnt_n  = '0;
        end else if (rcnt == RR_LAST) begin
          rep_pulse = 1'b1;
          rcnt_n    = '0;
        end else begin
          rcnt_n = rcnt + CNT_W'(1);
        end
      end
      HOLD: begin
        rcnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        rcnt_n  = '0;
      end
    endcase
    // A release wins over any repeat due in the same cycle.
    if (acc_rel) begin
      state_n   = IDLE;
      rcnt_n    = '0;
      rep_pulse = 1'b0;
    end
  end

endmodule

// File: rtl/key_debounce_repeat.sv
// Multi-channel key debouncer with press/release pulses and per-key auto-repeat.
// Each channel is filtered independently; timing is given in milliseconds.
module key_debounce_repeat
  import key_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int KEY_CNT         = 8,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 300,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_CNT-1:0] keys,
  input  logic [KEY_CNT-1:0] repeat_en,
  output logic [KEY_CNT-1:0] keys_stable,
  output logic [KEY_CNT-1:0] key_press,
  output logic [KEY_CNT-1:0] key_release,
  output logic [KEY_CNT-1:0] key_event
);

  localparam int DB_CYC  = ms_to_cyc(CLK_FREQ, DEBOUNCE_MS);
  localparam int RD_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_DELAY_MS);
  localparam int RR_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_RATE_MS);
  localparam int MAX_AB  = (DB_CYC > RD_CYC) ? DB_CYC : RD_CYC;
  localparam int MAX_CYC = (MAX_AB > RR_CYC) ? MAX_AB : RR_CYC;
  localparam int CNT_W   = cnt_w(MAX_CYC);

  // XOR mask turning pin polarity into "pressed = 1" and back.
  localparam logic [KEY_CNT-1:0] POL_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

  if (DB_CYC < 1 || RD_CYC < 1 || RR_CYC < 1) begin : g_bad_cfg
    $error("key_debounce_repeat: derived cycle counts must be at least 1");
  end

  logic [KEY_CNT-1:0] pressed_raw;
  logic [KEY_CNT-1:0] stable_p;

  assign pressed_raw = keys ^ POL_MASK;
  assign keys_stable = stable_p ^ POL_MASK;

  for (genvar i = 0; i < KEY_CNT; i++) begin : g_ch
    key_channel #(
      .DB_CYC(DB_CYC),
      .RD_CYC(RD_CYC),
      .RR_CYC(RR_CYC),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .pressed_raw(pressed_raw[i]),
      .repeat_en  (repeat_en[i]),
      .stable     (stable_p[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_event  (key_event[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench: DB_CYC=4, RD_CYC=10, RR_CYC=3, four active-low keys.
module tb_key_debounce_repeat;

  logic       clk;
  logic       rst_n;
  logic [3:0] keys;
  logic [3:0] repeat_en;
  logic [3:0] keys_stable;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_event;

  int n_assert = 0;
  int n_fail   = 0;

  key_debounce_repeat #(
    .CLK_FREQ       (1000),
    .KEY_CNT        (4),
    .DEBOUNCE_MS    (4),
    .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS (3),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .keys       (keys),
    .repeat_en  (repeat_en),
    .keys_stable(keys_stable),
    .key_press  (key_press),
    .key_release(key_release),
    .key_event  (key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Repeat schedule relative to the key_press cycle: offsets 10, 13, 16, ...
  function automatic logic rep_due(input int k);
    return (k >= 10) && ((k - 10) % 3 == 0);
  endfunction

  initial begin
    rst_n     = 1'b0;
    keys      = 4'b0000;
    repeat_en = 4'b0000;

    // 1. reset values, then all four held keys accepted 6 cycles after reset release
    #12;
    check("rst_stable", keys_stable, 4'b1111);
    check("rst_press", key_press, 4'b0000);
    check("rst_release", key_release, 4'b0000);
    check("rst_event", key_event, 4'b0000);
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t1_stable_wait", keys_stable, 4'b1111);
      check("t1_press_wait", key_press, 4'b0000);
    end
    tick();
    check("t1_stable", keys_stable, 4'b0000);
    check("t1_press", key_press, 4'b1111);
    check("t1_event", key_event, 4'b1111);
    check("t1_release", key_release, 4'b0000);
    tick();
    check("t1_press_end", key_press, 4'b0000);
    check("t1_event_end", key_event, 4'b0000);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("t1_hold_event", key_event, 4'b0000);
    end
    keys = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t1_rel_wait", key_release, 4'b0000);
    end
    tick();
    check("t1_rel", key_release, 4'b1111);
    check("t1_rel_stable", keys_stable, 4'b1111);
    tick();
    check("t1_rel_end", key_release, 4'b0000);

    // 2. bounce on key 0, accepted only 6 cycles after the last edge
    keys = 4'b1110; tick(); tick();
    check("t2_bounce_a", key_press, 4'b0000);
    keys = 4'b1111; tick(); tick();
    check("t2_bounce_b", key_press, 4'b0000);
    keys = 4'b1110;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t2_press_wait", key_press, 4'b0000);
      check("t2_stable_wait", keys_stable, 4'b1111);
    end
    tick();
    check("t2_press", key_press, 4'b0001);
    check("t2_stable", keys_stable, 4'b1110);
    tick();
    check("t2_press_end", key_press, 4'b0000);

    // 3 + 5. repeat on key 1, released so the release lands on a due repeat (offset 34)
    repeat_en = 4'b0010;
    keys      = 4'b1100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t3_press_wait", key_press, 4'b0000);
    end
    tick();
    check("t3_press", key_press, 4'b0010);
    check("t3_event_t", key_event, 4'b0010);
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("t3_repeat", key_event, rep_due(k) ? 4'b0010 : 4'b0000);
      if (k == 28) keys = 4'b1110;
    end
    tick();
    check("t5_release", key_release, 4'b0010);
    check("t5_no_event", key_event, 4'b0000);
    check("t5_stable", keys_stable, 4'b1110);
    for (int i = 0; i < 14; i++) begin
      tick();
      check("t5_idle_event", key_event, 4'b0000);
    end

    // 4. hold mode on key 2, raising repeat_en later has no effect
    repeat_en = 4'b0000;
    keys      = 4'b1010;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    check("t4_press", key_press, 4'b0100);
    check("t4_event", key_event, 4'b0100);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4_hold_a", key_event, 4'b0000);
    end
    repeat_en = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t4_hold_b", key_event, 4'b0000);
    end
    keys = 4'b1110;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    check("t4_release", key_release, 4'b0100);
    check("t4_rel_event", key_event, 4'b0000);
    repeat_en = 4'b0000;

    // 6. reset while key 3 is repeating; fresh acceptance afterwards
    repeat_en = 4'b1000;
    keys      = 4'b0110;
    for (int i = 1; i <= 5; i++) tick();
    tick();
    check("t6_press", key_press, 4'b1000);
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_stable", keys_stable, 4'b1111);
    check("t6_rst_press", key_press, 4'b0000);
    check("t6_rst_release", key_release, 4'b0000);
    check("t6_rst_event", key_event, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t6_wait_stable", keys_stable, 4'b1111);
      check("t6_wait_press", key_press, 4'b0000);
    end
    tick();
    check("t6_stable", keys_stable, 4'b0110);
    check("t6_repress", key_press, 4'b1001);
    check("t6_reevent", key_event, 4'b1001);
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("t6_delay", key_event, 4'b0000);
    end
    tick();
    check("t6_first_repeat", key_event, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
